// File: rtl/dp_ram_pkg.sv
// dp_ram_pkg: shared FSM state encoding and legal read-latency bounds for dp_ram_v2
package dp_ram_pkg;
  typedef enum logic {CLEAR, READY} state_t;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
endpackage

// File: rtl/dp_ram_rd_pipe.sv
// dp_ram_rd_pipe: read-data/valid pipeline of LAT stages; data holds between valids
module dp_ram_rd_pipe #(
  parameter int W   = 8,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data
);
  logic [LAT-1:0] r_v;
  logic [W-1:0]   r_d [LAT];
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= '0;
      for (int k = 0; k < LAT; k++) r_d[k] <= '0;
    end else begin
      r_v[0] <= i_valid;
      if (i_valid) r_d[0] <= i_data;
      for (int k = 1; k < LAT; k++) begin
        r_v[k] <= r_v[k-1];
        if (r_v[k-1]) r_d[k] <= r_d[k-1];
      end
    end
  end
  assign o_valid = r_v[LAT-1];
  assign o_data  = r_d[LAT-1];
endmodule

// File: rtl/dp_ram_v2.sv
// dp_ram_v2: byte-masked dual-port RAM with sequential clear after reset,
// configurable read latency, collision bypass and a sticky dropped-request flag
module dp_ram_v2
  import dp_ram_pkg::*;
#(
  parameter int RAM_width    = 8,
  parameter int RAM_depth    = 256,
  parameter int address_size = 8,
  parameter int READ_LATENCY = 1,
  parameter int BYPASS_EN    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    write_enable,
  input  logic [RAM_width/8-1:0]  byte_enable,
  input  logic [address_size-1:0] write_address,
  input  logic [RAM_width-1:0]    data_in,
  input  logic                    read_enable,
  input  logic [address_size-1:0] read_address,
  output logic [RAM_width-1:0]    data_out,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    access_err
);
  localparam int BW  = RAM_width / 8;
  localparam int AW  = $clog2(RAM_depth);
  localparam int LAT = (READ_LATENCY >= RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT_MIN;
  state_t                r_state, w_next;
  logic [AW-1:0]         r_clr_addr;
  logic                  r_err;
  logic [RAM_width-1:0]  r_mem [RAM_depth];
  logic                  w_busy, w_wr_in, w_rd_in, w_wr_ok, w_rd_ok, w_drop;
  logic [RAM_width-1:0]  w_rd_data;
  assign w_busy  = (r_state == CLEAR);
  assign w_wr_in = 32'(write_address) < RAM_depth;
  assign w_rd_in = 32'(read_address) < RAM_depth;
  assign w_wr_ok = write_enable & ~w_busy & w_wr_in & ~reset;
  assign w_rd_ok = read_enable & ~w_busy & ~reset;
  assign w_drop  = w_busy ? (write_enable | read_enable)
                          : ((write_enable & ~w_wr_in) | (read_enable & ~w_rd_in));
  assign w_next  = (w_busy && r_clr_addr == AW'(RAM_depth - 1)) ? READY : r_state;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_clr_addr <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_clr_addr <= w_busy ? r_clr_addr + 1'b1 : r_clr_addr;
      r_err      <= r_err | w_drop;
    end
  end
  // array has no reset: it is zeroed one word per cycle while busy
  always_ff @(posedge clk) begin
    if (w_busy) r_mem[r_clr_addr] <= '0;
    else if (w_wr_ok)
      for (int b = 0; b < BW; b++)
        if (byte_enable[b]) r_mem[write_address[AW-1:0]][8*b +: 8] <= data_in[8*b +: 8];
  end
  always_comb begin
    w_rd_data = w_rd_in ? r_mem[read_address[AW-1:0]] : '0;
    if (BYPASS_EN != 0 && w_wr_ok && write_address == read_address)
      for (int b = 0; b < BW; b++)
        if (byte_enable[b]) w_rd_data[8*b +: 8] = data_in[8*b +: 8];
  end
  dp_ram_rd_pipe #(.W(RAM_width), .LAT(LAT)) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_valid (w_rd_ok),
    .i_data  (w_rd_data),
    .o_valid (rd_valid),
    .o_data  (data_out)
  );
  assign busy       = w_busy;
  assign access_err = r_err;
endmodule

// File: tb/tb_dp_ram_v2.sv
// tb_dp_ram_v2: two 16-bit instances (latency 2 write-first, latency 1 read-first)
// driven in lockstep and scored against an array/queue reference model
module tb_dp_ram_v2;
  logic        clk = 1'b0;
  logic        reset, we, re;
  logic [1:0]  be;
  logic [8:0]  wa, ra;
  logic [15:0] din;
  logic [15:0] dout_a, dout_b;
  logic        vld_a, vld_b, busy_a, busy_b, err_a, err_b;

  typedef struct { int due; logic [15:0] d; } ent_t;
  logic [15:0] mem_m [256];
  ent_t        qa[$], qb[$];
  logic [15:0] last_a, last_b;
  int          clr_left, n, checks, fails;
  bit          err_m;

  always #5 clk = ~clk;

  dp_ram_v2 #(.RAM_width(16), .RAM_depth(256), .address_size(9), .READ_LATENCY(2), .BYPASS_EN(1)) u_a (
    .clk(clk), .reset(reset), .write_enable(we), .byte_enable(be), .write_address(wa),
    .data_in(din), .read_enable(re), .read_address(ra), .data_out(dout_a),
    .rd_valid(vld_a), .busy(busy_a), .access_err(err_a));
  dp_ram_v2 #(.RAM_width(16), .RAM_depth(256), .address_size(9), .READ_LATENCY(1), .BYPASS_EN(0)) u_b (
    .clk(clk), .reset(reset), .write_enable(we), .byte_enable(be), .write_address(wa),
    .data_in(din), .read_enable(re), .read_address(ra), .data_out(dout_b),
    .rd_valid(vld_b), .busy(busy_b), .access_err(err_b));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one clock: drive, advance the model, then compare every output
  task automatic step(input bit r, input bit w, input logic [1:0] b, input logic [8:0] wad,
                      input logic [15:0] d, input bit rd, input logic [8:0] rad);
    ent_t        e;
    logic [15:0] old, mrg;
    bit          va, vb;
    reset = r; we = w; be = b; wa = wad; din = d; re = rd; ra = rad;
    @(posedge clk);
    n++;
    if (r) begin
      clr_left = 256; qa.delete(); qb.delete(); err_m = 0; last_a = '0; last_b = '0;
      foreach (mem_m[i]) mem_m[i] = '0;
    end else if (clr_left > 0) begin
      if (w || rd) err_m = 1;
      clr_left--;
    end else begin
      if (rd) begin
        if (rad >= 256) begin old = '0; mrg = '0; err_m = 1; end
        else begin
          old = mem_m[rad[7:0]];
          mrg = old;
          if (w && wad == rad) begin
            if (b[0]) mrg[7:0]  = d[7:0];
            if (b[1]) mrg[15:8] = d[15:8];
          end
        end
        e.due = n + 1; e.d = mrg; qa.push_back(e);
        e.due = n;     e.d = old; qb.push_back(e);
      end
      if (w) begin
        if (wad >= 256) err_m = 1;
        else begin
          if (b[0]) mem_m[wad[7:0]][7:0]  = d[7:0];
          if (b[1]) mem_m[wad[7:0]][15:8] = d[15:8];
        end
      end
    end
    #1;
    va = qa.size() > 0 && qa[0].due == n;
    if (va) begin last_a = qa[0].d; void'(qa.pop_front()); end
    vb = qb.size() > 0 && qb[0].due == n;
    if (vb) begin last_b = qb[0].d; void'(qb.pop_front()); end
    chk("vld_a", 16'(vld_a), 16'(va));
    chk("dout_a", dout_a, last_a);
    chk("vld_b", 16'(vld_b), 16'(vb));
    chk("dout_b", dout_b, last_b);
    chk("busy_a", 16'(busy_a), 16'(clr_left > 0));
    chk("busy_b", 16'(busy_b), 16'(clr_left > 0));
    chk("err_a", 16'(err_a), 16'(err_m));
    chk("err_b", 16'(err_b), 16'(err_m));
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 2'b00, 9'd0, 16'h0, 0, 9'd0);
  endtask

  task automatic busy_span(input string tag);
    int fall = 0;
    for (int k = 1; k <= 300; k++) begin
      idle(1);
      if (!busy_a && fall == 0) fall = k;
    end
    chk(tag, 16'(fall), 16'd256);
  endtask

  initial begin
    int cnt_a, cnt_b;
    checks = 0; fails = 0; n = 0; clr_left = 256; err_m = 0; last_a = '0; last_b = '0;
    reset = 1; we = 0; re = 0; be = '0; wa = '0; ra = '0; din = '0;
    step(1, 0, 2'b00, 9'd0, 16'h0, 0, 9'd0);
    step(1, 0, 2'b00, 9'd0, 16'h0, 0, 9'd0);
    busy_span("busy_fall_initial");
    for (int i = 0; i < 256; i++) step(0, 0, 2'b00, 9'd0, 16'h0, 1, 9'(i));
    idle(2);
    step(0, 1, 2'b11, 9'h010, 16'h00A5, 0, 9'd0);
    step(0, 0, 2'b00, 9'd0, 16'h0, 1, 9'h010);
    chk("a5_b", dout_b, 16'h00A5);
    chk("a5_a_early", 16'(vld_a), 16'd0);
    idle(1);
    chk("a5_a_vld", 16'(vld_a), 16'd1);
    chk("a5_a", dout_a, 16'h00A5);
    step(0, 1, 2'b11, 9'd3, 16'h1234, 0, 9'd0);
    step(0, 1, 2'b01, 9'd3, 16'hABCD, 1, 9'd3);
    chk("coll_read_first", dout_b, 16'h1234);
    idle(1);
    chk("coll_write_first", dout_a, 16'h12CD);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b11, 9'(i), 16'($urandom), 0, 9'd0);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) step(0, 0, 2'b00, 9'd0, 16'h0, 1, 9'(i));
      else idle(1);
      cnt_a += int'(vld_a); cnt_b += int'(vld_b);
    end
    chk("b2b_a", 16'(cnt_a), 16'd8);
    chk("b2b_b", 16'(cnt_b), 16'd8);
    for (int i = 0; i < 400; i++)
      step(0, 1'($urandom_range(0, 1)), 2'($urandom), 
           ($urandom_range(0, 15) == 0) ? 9'(256 + $urandom_range(0, 255)) : 9'($urandom_range(0, 15)),
           16'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0) ? 9'(256 + $urandom_range(0, 255)) : 9'($urandom_range(0, 15)));
    step(0, 0, 2'b00, 9'd0, 16'h0, 1, 9'd3);
    step(1, 0, 2'b00, 9'd0, 16'h0, 0, 9'd0);
    chk("err_cleared", 16'(err_a), 16'd0);
    idle(5);
    step(0, 0, 2'b00, 9'd0, 16'h0, 1, 9'd7);
    chk("busy_read_err", 16'(err_a), 16'd1);
    chk("busy_read_novld", 16'(vld_b), 16'd0);
    idle(300);
    chk("err_sticky", 16'(err_b), 16'd1);
    step(1, 0, 2'b00, 9'd0, 16'h0, 0, 9'd0);
    idle(100);
    step(1, 0, 2'b00, 9'd0, 16'h0, 0, 9'd0);
    busy_span("busy_fall_restart");
    for (int i = 0; i < 4; i++) step(0, 0, 2'b00, 9'd0, 16'h0, 1, 9'(250 + i));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
